lock_reg_arbiter: RTL and testbench
===================================

LOCK_REG_ARBITER -- requirements
Module: lock_reg_arbiter

Interface
REQ-001 Parameter: DATA_W, 16, register and data width in bits (min 2).
REQ-002 Parameter: NREG, 4, number of write-once registers (power of 2, min 2); ADDR_W = clog2(NREG).
REQ-003 Port: Clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: ip_resetn  input  1  reset, asynchronous, active-low.
REQ-005 Port: req  input  2  per-requester access request; held high until ack.
REQ-006 Port: we  input  2  per-requester write enable (1 write, 0 read); stable while req high.
REQ-007 Port: addr0, addr1  input  ADDR_W each  requester 0/1 register index.
REQ-008 Port: wdata0, wdata1  input  DATA_W each  requester 0/1 write data; bit 0 is the lock request.
REQ-009 Port: gnt  output  2  one-hot owner of current transaction, 0 when idle.
REQ-010 Port: ack  output  1  one-cycle completion pulse for owner named by gnt.
REQ-011 Port: err  output  1  valid with ack; 1 = write to locked register rejected.
REQ-012 Port: rdata  output  DATA_W  valid with ack; register contents, bit 0 = lock bit.
REQ-013 Port: lock_status  output  NREG  live lock bit of each register.

Function
REQ-014 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any req bit high; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-015 In IDLE, winner: single requester if one req high; if both high, requester indicated by round-robin pointer rr.
REQ-016 On IDLE->ACCESS: latch winner's we, addr, wdata; set gnt one-hot to winner; gnt held through ACCESS and RESP, cleared on return to IDLE.
REQ-017 rr updates in RESP to the non-owner; one transaction per requester alternates when both continuously request.
REQ-018 ACCESS, write, lock bit of addressed register 0: register[DATA_W-1:1] <= wdata[DATA_W-1:1], lock <= wdata[0]; err flag 0.
REQ-019 ACCESS, write, lock bit 1: register and lock unchanged; err flag 1.
REQ-020 ACCESS, read: no state change; err flag 0.
REQ-021 RESP: ack=1, err per REQ-018..020, rdata = addressed register value after the ACCESS update ({data[DATA_W-1:1], lock}).
REQ-022 ack and err are 0, rdata is 0 in all states other than RESP.
REQ-023 Latency: req sampled high in IDLE at edge N -> ack high in cycle after edge N+2; minimum 3 cycles per transaction, no back-to-back overlap.
REQ-024 Requester dropping req after grant: transaction still completes, ack still pulses.
REQ-025 Once set, a lock bit clears only by reset; writes of wdata[0]=0 to locked register are rejected (REQ-019).
REQ-026 Write of wdata[0]=1 to unlocked register stores data and locks in same access; next write errors.
REQ-027 lock_status[i] reflects lock bit of register i, updating the cycle after ACCESS.

Reset
REQ-028 ip_resetn low, asynchronously: state IDLE, gnt=0, ack=0, err=0, rdata=0, all registers 0, all locks 0, lock_status=0, rr=0.
REQ-029 Reset during ACCESS or RESP aborts transaction; no ack issued; owner must re-request.

Configuration
REQ-030 Macro LOCK_VIOLATION_CNT_EN defined: extra output viol_cnt  output  8, incremented in ACCESS on each rejected write, saturating at 255, reset to 0.
REQ-031 Macro undefined: no viol_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-032 Reset, req=01, we0=1, addr0=2, wdata0=16'h1234 -> ack 3rd cycle, err=0, rdata=16'h1234, lock_status=0000.
REQ-033 Then req=01, we0=1, addr0=2, wdata0=16'hABCD -> rdata=16'hABCD, err=0, lock_status=0100; repeat with 16'h5550 -> err=1, rdata=16'hABCD.
REQ-034 Both req held high 6 transactions from reset -> gnt sequence 01,10,01,10,01,10.
REQ-035 ip_resetn pulsed low during ACCESS -> no ack, all outputs 0, lock_status=0; subsequent read of register returns 16'h0000.
REQ-036 With LOCK_VIOLATION_CNT_EN: 300 writes to a locked register -> viol_cnt=255, all err=1.

Source files
------------

// File: rtl/lock_reg_arbiter.sv
// Two-requester round-robin arbiter in front of NREG write-once (lockable) registers.
// Optional build macro LOCK_VIOLATION_CNT_EN adds an 8-bit saturating rejected-write counter (viol_cnt).
module lock_reg_arbiter #(
  parameter  int DATA_W = 16,
  parameter  int NREG   = 4,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic              Clk,
  input  logic              ip_resetn,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [NREG-1:0]   lock_status
`ifdef LOCK_VIOLATION_CNT_EN
  ,
  output logic [7:0]        viol_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rr_q, rr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];
  logic                win;
  logic [DATA_W-1:0]   cur;
`ifdef LOCK_VIOLATION_CNT_EN
  logic [7:0]          viol_cnt_q, viol_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    rr_d    = rr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    regs_d  = regs_q;
    win     = 1'b0;
    cur     = regs_q[addr_q];
`ifdef LOCK_VIOLATION_CNT_EN
    viol_cnt_d = viol_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        gnt_d = 2'b00;
        if (|req) begin
          // Contention is resolved by the pointer; a lone requester always wins.
          win     = (req == 2'b11) ? rr_q : req[1];
          state_d = ACCESS;
          gnt_d   = win ? 2'b10 : 2'b01;
          we_d    = we[win];
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        state_d = RESP;
        ack_d   = 1'b1;
        rdata_d = cur;
        if (we_q) begin
          if (cur[0]) begin
            err_d = 1'b1;
`ifdef LOCK_VIOLATION_CNT_EN
            if (viol_cnt_q != 8'hFF) viol_cnt_d = viol_cnt_q + 8'd1;
`endif
          end else begin
            // Data and lock bit are stored together, so a locking write takes effect at once.
            regs_d[addr_q] = wdata_q;
            rdata_d        = wdata_q;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        rr_d    = gnt_q[0];
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge ip_resetn) begin
    if (!ip_resetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rr_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
`ifdef LOCK_VIOLATION_CNT_EN
      viol_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rr_q    <= rr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
`ifdef LOCK_VIOLATION_CNT_EN
      viol_cnt_q <= viol_cnt_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;
`ifdef LOCK_VIOLATION_CNT_EN
  assign viol_cnt = viol_cnt_q;
`endif

  for (genvar gi = 0; gi < NREG; gi++) begin : g_lock
    assign lock_status[gi] = regs_q[gi][0];
  end

endmodule

// File: tb/tb_lock_reg_arbiter.sv
// Self-checking bench for lock_reg_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the register file.
module tb_lock_reg_arbiter;

  localparam int DATA_W = 16;
  localparam int NREG   = 4;

  logic              clk;
  logic              ip_resetn;
  logic [1:0]        req;
  logic [1:0]        we;
  logic [1:0]        addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic [1:0]        gnt;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic [NREG-1:0]   lock_status;
`ifdef LOCK_VIOLATION_CNT_EN
  logic [7:0]        viol_cnt;
`endif

  lock_reg_arbiter #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .Clk(clk), .ip_resetn(ip_resetn), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .ack(ack), .err(err), .rdata(rdata), .lock_status(lock_status)
`ifdef LOCK_VIOLATION_CNT_EN
    , .viol_cnt(viol_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit run      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Transaction-level model: a grant starts a 2-cycle countdown; the register
  // effect lands when the countdown passes its first step, the reply shows on the second.
  logic [DATA_W-1:0] m_mem [NREG];
  int                m_timer;
  int                m_owner;
  int                m_pri;
  bit                m_we;
  int                m_addr;
  logic [DATA_W-1:0] m_wdata;
  bit                m_err;
  logic [DATA_W-1:0] m_rdata;
  int                m_viol;

  always @(posedge clk or negedge ip_resetn) begin
    if (!ip_resetn) begin
      for (int i = 0; i < NREG; i++) m_mem[i] = '0;
      m_timer = 0; m_owner = 0; m_pri = 0; m_err = 0; m_rdata = '0; m_viol = 0;
    end else if (m_timer == 2) begin
      m_err = 0;
      if (m_we) begin
        if (m_mem[m_addr][0]) begin
          m_err = 1;
          if (m_viol < 255) m_viol++;
        end else begin
          m_mem[m_addr] = m_wdata;
        end
      end
      m_rdata = m_mem[m_addr];
      m_timer = 1;
    end else if (m_timer == 1) begin
      m_timer = 0;
      m_pri   = 1 - m_owner;
    end else if (req != 2'b00) begin
      m_owner = (req == 2'b11) ? m_pri : (req[1] ? 1 : 0);
      m_we    = we[m_owner];
      m_addr  = (m_owner == 1) ? int'(addr1) : int'(addr0);
      m_wdata = (m_owner == 1) ? wdata1 : wdata0;
      m_timer = 2;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      logic [1:0]        e_gnt;
      logic [NREG-1:0]   e_ls;
      e_gnt = (m_timer != 0) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
      for (int i = 0; i < NREG; i++) e_ls[i] = m_mem[i][0];
      chk("cyc_gnt", 32'(gnt), 32'(e_gnt));
      chk("cyc_ack", 32'(ack), 32'(m_timer == 1));
      chk("cyc_err", 32'(err), (m_timer == 1) ? 32'(m_err) : 32'd0);
      chk("cyc_rdata", 32'(rdata), (m_timer == 1) ? 32'(m_rdata) : 32'd0);
      chk("cyc_lock", 32'(lock_status), 32'(e_ls));
`ifdef LOCK_VIOLATION_CNT_EN
      chk("cyc_viol", 32'(viol_cnt), 32'(m_viol));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    ip_resetn = 1'b0;
    tick();
    ip_resetn = 1'b1;
    tick();
  endtask

  task automatic set_req(input int r, input bit w, input int a, input logic [DATA_W-1:0] d);
    we[r] = w;
    if (r == 1) begin addr1 = 2'(a); wdata1 = d; end
    else        begin addr0 = 2'(a); wdata0 = d; end
    req[r] = 1'b1;
  endtask

  task automatic do_txn(input int r, input bit w, input int a, input logic [DATA_W-1:0] d,
                        output logic [DATA_W-1:0] rd, output bit e,
                        output logic [NREG-1:0] ls, output int lat);
    bit got = 0;
    set_req(r, w, a, d);
    lat = 0; rd = '0; e = 0; ls = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      lat++;
      if (ack) begin
        got = 1; rd = rdata; e = err; ls = lock_status;
        break;
      end
    end
    if (!got) chk("txn_timeout", 32'd0, 32'd1);
    req[r] = 1'b0;
    tick();
  endtask

  task automatic new_params(input int i);
    logic [DATA_W-1:0] d;
    d = {15'($urandom), ($urandom_range(0, 5) == 0)};
    set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, NREG - 1)), d);
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    logic [NREG-1:0]   ls;
    bit                e;
    int                lat;
    int                k;

    req = 2'b00; we = 2'b00; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    ip_resetn = 1'b0;
    run = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_lock", 32'(lock_status), 32'd0);
    ip_resetn = 1'b1;
    tick();

    // Write-once sequence on register 2.
    do_txn(0, 1, 2, 16'h1234, rd, e, ls, lat);
    chk("w1_latency", 32'(lat), 32'd2);
    chk("w1_rdata", 32'(rd), 32'h1234);
    chk("w1_err", 32'(e), 32'd0);
    chk("w1_lock", 32'(ls), 32'b0000);
    do_txn(0, 1, 2, 16'hABCD, rd, e, ls, lat);
    chk("w2_rdata", 32'(rd), 32'hABCD);
    chk("w2_err", 32'(e), 32'd0);
    chk("w2_lock", 32'(ls), 32'b0100);
    do_txn(0, 1, 2, 16'h5550, rd, e, ls, lat);
    chk("w3_err", 32'(e), 32'd1);
    chk("w3_rdata", 32'(rd), 32'hABCD);
    chk("w3_lock", 32'(ls), 32'b0100);
    do_txn(1, 0, 2, 16'h0000, rd, e, ls, lat);
    chk("r1_rdata", 32'(rd), 32'hABCD);
    chk("r1_err", 32'(e), 32'd0);

    // Round-robin under continuous contention.
    apply_reset();
    set_req(0, 0, 0, '0);
    set_req(1, 0, 1, '0);
    k = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (ack) begin
        chk("rr_gnt", 32'(gnt), (k % 2 == 0) ? 32'b01 : 32'b10);
        k++;
        if (k == 6) break;
      end
    end
    req = 2'b00;
    chk("rr_count", 32'(k), 32'd6);
    tick();

    // Reset during ACCESS aborts the transaction and clears locks.
    do_txn(0, 1, 2, 16'h00FF, rd, e, ls, lat);
    chk("lk_lock", 32'(ls), 32'b0100);
    set_req(0, 1, 2, 16'h1111);
    tick();
    chk("ab_gnt", 32'(gnt), 32'b01);
    ip_resetn = 1'b0;
    req = 2'b00;
    #1;
    chk("ab_gnt0", 32'(gnt), 32'd0);
    chk("ab_ack0", 32'(ack), 32'd0);
    chk("ab_rdata0", 32'(rdata), 32'd0);
    chk("ab_lock0", 32'(lock_status), 32'd0);
    tick();
    ip_resetn = 1'b1;
    tick();
    do_txn(0, 0, 2, 16'h0000, rd, e, ls, lat);
    chk("ab_read", 32'(rd), 32'h0000);
    chk("ab_read_err", 32'(e), 32'd0);

`ifdef LOCK_VIOLATION_CNT_EN
    apply_reset();
    do_txn(1, 1, 1, 16'h0003, rd, e, ls, lat);
    for (int i = 0; i < 300; i++) begin
      do_txn(1, 1, 1, 16'($urandom), rd, e, ls, lat);
      chk("viol_err", 32'(e), 32'd1);
    end
    chk("viol_sat", 32'(viol_cnt), 32'd255);
`endif

    // Randomized traffic, including early drops and occasional resets.
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        ip_resetn = 1'b0;
        tick();
        ip_resetn = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
        if (req[i]) begin
          if (ack && gnt[i]) begin
            req[i] = 1'($urandom_range(0, 1));
            if (req[i]) new_params(i);
          end else if (gnt[i] && $urandom_range(0, 9) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          new_params(i);
        end
      end
      tick();
    end
    req = 2'b00;
    repeat (4) tick();

    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
